pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 61 ++++++
 tb/tb_pc_fetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Purpose: PC register plus IF/ID pipeline register with branch/jump redirect and hazard stall.
// Latency: 1 cycle from redirect to pcOutput=target; target instruction lands in IF/ID one cycle later.
// Backpressure: stallInput freezes PC and IF/ID and suppresses any redirect that cycle.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stallInput,
    input  logic        branchControlInput,
    input  logic [31:0] branchTargetInput,
    input  logic        jumpInput,
    input  logic [25:0] jumpIndexInput,
    input  logic [31:0] instructionInput,
    output logic [31:0] pcOutput,
    output logic [31:0] ifIdInstructionOutput,
    output logic [31:0] ifIdPcPlus4Output,
    output logic        ifIdValidOutput,
    output logic        flushOutput
);
    localparam logic [31:0] STEP     = 32'(PC_STEP);
    localparam logic [31:0] ALIGN    = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_RESET = RESET_PC & ALIGN;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus_step;

    always_comb begin
        redirect     = (branchControlInput | jumpInput) & ~stallInput & ~reset;
        // A simultaneous branch and jump resolves to the branch target.
        target       = branchControlInput ? branchTargetInput
                                          : {ifIdPcPlus4Output[31:28], jumpIndexInput, 2'b00};
        pc_plus_step = pcOutput + STEP;
    end

    assign flushOutput = redirect;

    always_ff @(posedge clock) begin
        if (reset) begin
            pcOutput              <= PC_RESET;
            ifIdInstructionOutput <= 32'h0;
            ifIdPcPlus4Output     <= 32'h0;
            ifIdValidOutput       <= 1'b0;
        end else if (!stallInput) begin
            if (redirect) begin
                // The instruction fetched this cycle is wrong-path, so IF/ID becomes a bubble.
                pcOutput              <= target & ALIGN;
                ifIdInstructionOutput <= 32'h0;
                ifIdPcPlus4Output     <= 32'h0;
                ifIdValidOutput       <= 1'b0;
            end else begin
                pcOutput              <= pc_plus_step & ALIGN;
                ifIdInstructionOutput <= instructionInput;
                ifIdPcPlus4Output     <= pc_plus_step;
                ifIdValidOutput       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench: the driver pushes model expectations, a negedge monitor pops and compares.
module tb_pc_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reset2 = 1'b1;
    logic        stallInput = 1'b0;
    logic        branchControlInput = 1'b0;
    logic [31:0] branchTargetInput = 32'h0;
    logic        jumpInput = 1'b0;
    logic [25:0] jumpIndexInput = 26'h0;
    logic [31:0] instructionInput = 32'h0;
    logic [31:0] pcOutput, ifIdInstructionOutput, ifIdPcPlus4Output;
    logic        ifIdValidOutput, flushOutput;
    logic [31:0] pc2, ins2, pp42;
    logic        vld2, flush2;

    always #5 clock = ~clock;

    pc_fetch_unit dut (
        .clock(clock), .reset(reset), .stallInput(stallInput),
        .branchControlInput(branchControlInput), .branchTargetInput(branchTargetInput),
        .jumpInput(jumpInput), .jumpIndexInput(jumpIndexInput),
        .instructionInput(instructionInput), .pcOutput(pcOutput),
        .ifIdInstructionOutput(ifIdInstructionOutput), .ifIdPcPlus4Output(ifIdPcPlus4Output),
        .ifIdValidOutput(ifIdValidOutput), .flushOutput(flushOutput)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
        .clock(clock), .reset(reset2), .stallInput(1'b0),
        .branchControlInput(1'b0), .branchTargetInput(32'h0),
        .jumpInput(1'b0), .jumpIndexInput(26'h0),
        .instructionInput(32'h0), .pcOutput(pc2),
        .ifIdInstructionOutput(ins2), .ifIdPcPlus4Output(pp42),
        .ifIdValidOutput(vld2), .flushOutput(flush2)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pp4;
        logic        vld;
    } st_t;

    typedef struct {
        st_t         s;
        logic        flush;
        logic [31:0] pc2;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    st_t         m;
    logic [31:0] m_pc2;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] imem(input logic [31:0] pc);
        return 32'hAAAA0000 + pc;
    endfunction

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h at %0t", tag, name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, record what the outputs must be during this cycle, advance the model.
    task automatic step(input logic rst, input logic stl, input logic br, input logic [31:0] tgt,
                        input logic jmp, input logic [25:0] idx, input string tag);
        exp_t        e;
        logic        redir;
        logic [31:0] t;
        reset              = rst;
        stallInput         = stl;
        branchControlInput = br;
        branchTargetInput  = tgt;
        jumpInput          = jmp;
        jumpIndexInput     = idx;
        instructionInput   = imem(m.pc);
        redir   = !rst && !stl && (br || jmp);
        e.s     = m;
        e.flush = redir;
        e.pc2   = m_pc2;
        e.tag   = tag;
        sb_q.push_back(e);
        if (rst) begin
            m = '{pc: 32'h0, ins: 32'h0, pp4: 32'h0, vld: 1'b0};
        end else if (stl) begin
            m = m;
        end else if (redir) begin
            t = br ? tgt : ((m.pp4 & 32'hF000_0000) | ({6'b0, idx} * 4));
            m = '{pc: t & ~32'd3, ins: 32'h0, pp4: 32'h0, vld: 1'b0};
        end else begin
            m = '{pc: (m.pc + 4) & ~32'd3, ins: imem(m.pc), pp4: m.pc + 4, vld: 1'b1};
        end
        m_pc2 = reset2 ? 32'hFFFF_FFF8 : m_pc2 + 4;
        @(posedge clock);
        #1;
        reset2 = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("pc",    e.tag, pcOutput,               e.s.pc);
                chk("ins",   e.tag, ifIdInstructionOutput,  e.s.ins);
                chk("pp4",   e.tag, ifIdPcPlus4Output,      e.s.pp4);
                chk("valid", e.tag, {31'b0, ifIdValidOutput}, {31'b0, e.s.vld});
                chk("flush", e.tag, {31'b0, flushOutput},   {31'b0, e.flush});
                chk("wrap_pc", e.tag, pc2,                  e.pc2);
            end
        end
    end

    initial begin : driver
        int budget;
        @(posedge clock);
        #1;
        m     = '{pc: 32'h0, ins: 32'h0, pp4: 32'h0, vld: 1'b0};
        m_pc2 = 32'hFFFF_FFF8;
        reset2 = 1'b0;

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, "reset");
        idle("seq0");
        idle("seq1");
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 26'h0, "branch_at_8");
        idle("after_branch");
        step(1'b0, 1'b0, 1'b1, 32'h3000_000F, 1'b0, 26'h0, "branch_unaligned");
        idle("seq_3000");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h0000040, "jump");
        idle("after_jump");
        idle("seq_fill");
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 26'h0, "stall_br0");
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 26'h0, "stall_br1");
        step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 26'h0, "br_after_stall");
        idle("after_stall_br");
        step(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 26'h3FF_FFFF, "br_and_jump");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h0000123, "b2b_jump");
        step(1'b0, 1'b0, 1'b1, 32'h800, 1'b0, 26'h0, "b2b_branch");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h0000010, "b2b_jump2");
        idle("after_b2b");
        idle("seq_pre_reset");
        step(1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 26'h0, "reset_with_branch");
        idle("after_reset_br");
        idle("seq_r");
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 26'h1, "reset_with_stall");
        idle("after_reset_stall");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0),
                 $urandom(),
                 ($urandom_range(0, 9) == 0),
                 26'($urandom()),
                 "random");
        end

        budget = 0;
        while (sb_q.size() != 0 && budget < 10) begin
            @(negedge clock);
            budget++;
        end
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
